// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and default sizing.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hz_state_e;

    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_REGW    = 5;
    localparam int DEF_CNTW    = 16;
    localparam int MUL_CNT_W   = 4;
    localparam int REG_ZERO    = 0;

endpackage

// File: rtl/hz_load_use_cmp.sv
// Load-use comparator: flags an ID source that reads the register a load in EX is still fetching.
// Purely combinational, zero latency; no flow control.
module hz_load_use_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REGW = DEF_REGW
) (
    input  logic            ex_valid_i,
    input  logic            ex_is_load_i,
    input  logic [REGW-1:0] ex_rd_i,
    input  logic [REGW-1:0] id_rs1_i,
    input  logic [REGW-1:0] id_rs2_i,
    input  logic            id_uses_rs1_i,
    input  logic            id_uses_rs2_i,
    output logic            load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired, so a load targeting it can never create a real dependency.
    assign load_use_o = ex_valid_i && ex_is_load_i && (ex_rd_i != REGW'(REG_ZERO))
                        && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for IF/ID, ID/EX, EX/MEM: multiply occupancy > branch flush > load-use.
// Outputs combinational from state and inputs; stall_cycles registered, saturating.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int REGW    = DEF_REGW,
    parameter int CNTW    = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            ex_valid,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_is_load,
    input  logic            ex_is_mul,
    input  logic            br_taken,
    output logic            hold_if_id,
    output logic            hold_id_ex,
    output logic            kill_if_id,
    output logic            kill_id_ex,
    output logic            kill_ex_mem,
    output logic            mul_busy,
    output logic [CNTW-1:0] stall_cycles
);

    localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT = MUL_CNT_W'(MUL_LAT - 2);

    hz_state_e              state_q, state_d;
    logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNTW-1:0]        stall_q, stall_d;

    logic load_use;
    logic mul_entry;
    logic mul_stall;

    hz_load_use_cmp #(
        .REGW(REGW)
    ) u_lu_cmp (
        .ex_valid_i    (ex_valid),
        .ex_is_load_i  (ex_is_load),
        .ex_rd_i       (ex_rd),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .load_use_o    (load_use)
    );

    assign mul_entry = (state_q == RUN) && ex_valid && ex_is_mul;
    // The release cycle (MUL_WAIT, cnt==0) is not a stall, so it behaves like RUN below.
    assign mul_stall = mul_entry || ((state_q == MUL_WAIT) && (cnt_q != '0));

    always_comb begin
        hold_if_id  = 1'b0;
        hold_id_ex  = 1'b0;
        kill_if_id  = 1'b0;
        kill_id_ex  = 1'b0;
        kill_ex_mem = 1'b0;
        mul_busy    = 1'b0;
        if (rst) begin
            kill_if_id  = 1'b1;
            kill_id_ex  = 1'b1;
            kill_ex_mem = 1'b1;
        end else if (mul_stall) begin
            hold_if_id  = 1'b1;
            hold_id_ex  = 1'b1;
            kill_ex_mem = 1'b1;
            mul_busy    = 1'b1;
        end else if (br_taken) begin
            kill_if_id  = 1'b1;
            kill_id_ex  = 1'b1;
        end else if (load_use) begin
            hold_if_id  = 1'b1;
            kill_id_ex  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mul_entry) begin
                    state_d = MUL_WAIT;
                    cnt_d   = MUL_CNT_INIT;
                end
            end
            MUL_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign stall_d = (hold_if_id && (stall_q != '1)) ? stall_q + CNTW'(1) : stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an occupancy-based reference model checked every cycle.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int REGW    = 5;

    logic            clk;
    logic            rst;
    logic [REGW-1:0] id_rs1, id_rs2, ex_rd;
    logic            id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, ex_is_mul, br_taken;

    logic        hold_if_id, hold_id_ex, kill_if_id, kill_id_ex, kill_ex_mem, mul_busy;
    logic [15:0] stall_cycles;
    logic        h4_if_id, h4_id_ex, k4_if_id, k4_id_ex, k4_ex_mem, busy4;
    logic [3:0]  stall4;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul), .br_taken(br_taken),
        .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex), .kill_if_id(kill_if_id),
        .kill_id_ex(kill_id_ex), .kill_ex_mem(kill_ex_mem), .mul_busy(mul_busy),
        .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_mul(ex_is_mul), .br_taken(br_taken),
        .hold_if_id(h4_if_id), .hold_id_ex(h4_id_ex), .kill_if_id(k4_if_id),
        .kill_id_ex(k4_id_ex), .kill_ex_mem(k4_ex_mem), .mul_busy(busy4),
        .stall_cycles(stall4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: occ counts how many cycles the current multiply has already spent in EX.
    int         occ = 0;
    int         c16 = 0;
    int         c4  = 0;
    bit         started = 1'b0;
    logic [5:0] exp_o;
    logic [5:0] act_o, act4_o;

    // Bit order: hold_if_id, hold_id_ex, kill_if_id, kill_id_ex, kill_ex_mem, mul_busy
    function automatic logic [5:0] model_out(input int occ_now);
        bit lu, stall;
        if (rst) return 6'b001110;
        stall = (occ_now == 0 && ex_valid && ex_is_mul) ||
                (occ_now >= 1 && occ_now <= MUL_LAT - 2);
        if (stall) return 6'b110011;
        if (br_taken) return 6'b001100;
        lu = ex_valid && ex_is_load && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (lu) return 6'b100100;
        return 6'b000000;
    endfunction

    always_comb exp_o = model_out(occ);
    assign act_o  = {hold_if_id, hold_id_ex, kill_if_id, kill_id_ex, kill_ex_mem, mul_busy};
    assign act4_o = {h4_if_id, h4_id_ex, k4_if_id, k4_id_ex, k4_ex_mem, busy4};

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            occ <= 0;
            c16 <= 0;
            c4  <= 0;
        end else begin
            if (exp_o[5]) begin
                c16 <= (c16 < 65535) ? c16 + 1 : c16;
                c4  <= (c4 < 15) ? c4 + 1 : c4;
            end
            if (occ == 0)
                occ <= (ex_valid && ex_is_mul) ? 1 : 0;
            else
                occ <= (occ + 1 == MUL_LAT) ? 0 : occ + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Advance one cycle; the model comparison happens on the negedge inside the cycle.
    task automatic tick();
        @(negedge clk);
        if (started) begin
            chk("outs", int'(act_o), int'(exp_o));
            chk("outs_w4", int'(act4_o), int'(exp_o));
            chk("stall_cycles", int'(stall_cycles), c16);
            chk("stall_cycles_w4", int'(stall4), c4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0;
        ex_is_load = 0; ex_is_mul = 0; br_taken = 0;
    endtask

    task automatic set_lu(input logic [REGW-1:0] r);
        ex_valid = 1; ex_is_load = 1; ex_rd = r; id_rs2 = r; id_uses_rs2 = 1;
    endtask

    initial begin
        rst = 1;
        set_idle();
        #1;
        chk("reset_outs", int'(act_o), 6'b001110);
        tick();
        tick();
        chk("reset_stall", int'(stall_cycles), 0);
        rst = 0;

        // Load-use on rs2
        set_lu(5'd5);
        #1;
        chk("lu_hold_if_id", hold_if_id, 1);
        chk("lu_kill_id_ex", kill_id_ex, 1);
        chk("lu_hold_id_ex", hold_id_ex, 0);
        tick();
        ex_valid = 0;
        #1;
        chk("lu_bubble_no_hold", hold_if_id, 0);
        chk("lu_stall_count", int'(stall_cycles), 1);
        tick();

        // x0 destination never stalls; unused rs1 never stalls
        set_idle(); set_lu(5'd0);
        #1 chk("lu_r0", hold_if_id, 0);
        tick();
        set_idle(); ex_valid = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0;
        #1 chk("lu_rs1_unused", hold_if_id, 0);
        tick();
        id_uses_rs1 = 1;
        #1 chk("lu_rs1_used", hold_if_id, 1);
        tick();
        chk("lu_stall_count2", int'(stall_cycles), 2);

        // Two back-to-back multiplies, branch ignored while stalled
        set_idle(); ex_valid = 1; ex_is_mul = 1;
        for (int i = 0; i < 8; i++) begin
            br_taken = (i == 5);
            #1;
            chk("mul_busy", mul_busy, (i == 3 || i == 7) ? 0 : 1);
            chk("mul_kill_ex_mem", kill_ex_mem, (i == 3 || i == 7) ? 0 : 1);
            chk("mul_kill_if_id", kill_if_id, 0);
            if (i == 3) chk("mul_stall_count", int'(stall_cycles), 5);
            tick();
        end
        set_idle();
        chk("mul2_stall_count", int'(stall_cycles), 8);

        // Branch alone, then branch beating load-use
        br_taken = 1;
        #1;
        chk("br_kill_if_id", kill_if_id, 1);
        chk("br_kill_id_ex", kill_id_ex, 1);
        chk("br_hold_if_id", hold_if_id, 0);
        tick();
        set_lu(5'd9);
        #1;
        chk("br_lu_hold", hold_if_id, 0);
        chk("br_lu_kill", kill_if_id, 1);
        tick();
        set_idle();
        chk("br_stall_count", int'(stall_cycles), 8);

        // Reset in cycle 1 of a multiply
        ex_valid = 1; ex_is_mul = 1;
        tick();
        rst = 1;
        #1 chk("rst_mid_mul_outs", int'(act_o), 6'b001110);
        tick();
        rst = 0; set_idle();
        #1;
        chk("rst_mul_busy", mul_busy, 0);
        chk("rst_stall", int'(stall_cycles), 0);
        chk("rst_stall_w4", int'(stall4), 0);
        tick();

        // Load-use on the release cycle of a multiply
        ex_valid = 1; ex_is_mul = 1;
        tick(); tick(); tick();
        ex_is_mul = 0; ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
        #1;
        chk("rel_lu_outs", int'(act_o), 6'b100100);
        chk("rel_stall_count", int'(stall_cycles), 3);
        tick();
        ex_valid = 0;
        #1;
        chk("rel_after_outs", int'(act_o), 6'b000000);
        chk("rel_after_count", int'(stall_cycles), 4);
        tick();

        // Saturation of the narrow counter
        rst = 1; set_idle();
        tick();
        rst = 0;
        set_lu(5'd12);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_w4", int'(stall4), 15);
        chk("sat_w16", int'(stall_cycles), 20);
        tick(); tick();
        chk("sat_w4_hold", int'(stall4), 15);
        set_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
